// File: rtl/combo_pkg.sv
// Shared types and constants for the switch/LED combination-lock initiator.
package combo_pkg;

    localparam int CODE_LEN = 4;
    localparam int SW_W     = 5;
    localparam int LED_W    = 8;

    localparam logic [SW_W-1:0]  IDLE_PAT = 5'h0F;
    localparam logic [LED_W-1:0] LED_OPEN = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS,
        ST_RELEASE,
        ST_CHECK,
        ST_DONE
    } state_e;

    // A code word equal to the idle pattern is indistinguishable from a release.
    function automatic logic has_idle_word(input logic [CODE_LEN*SW_W-1:0] code);
        has_idle_word = 1'b0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (code[i*SW_W +: SW_W] == IDLE_PAT) begin
                has_idle_word = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/combo_phase_timer.sv
// Loadable down-counter shared by the press, release and check phases.
module combo_phase_timer #(
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/combo_sender.sv
// Drives a four-word code onto the switch bus, then watches the LED bus for unlock.
module combo_sender
    import combo_pkg::*;
#(
    parameter int HOLD_CYCLES    = 4,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic [CODE_LEN*SW_W-1:0] i_code,
    input  logic [LED_W-1:0]         i_led,
    output logic [SW_W-1:0]          o_switch,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_pass,
    output logic                     o_fail
);

    localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_CYC = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC) + 1;

    localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LD  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LD  = TMR_W'(TIMEOUT_CYCLES - 1);

    state_e           state;
    logic [1:0]       idx;
    logic [SW_W-1:0]  code_q [CODE_LEN];
    logic             start_ok;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_zero;

    // Abort outranks start even while idle.
    assign start_ok = i_start && !i_abort;

    combo_phase_timer #(.W(TMR_W)) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = HOLD_LD;
        case (state)
            ST_IDLE:    tmr_load = start_ok;
            ST_PRESS: begin
                tmr_load = tmr_zero;
                tmr_val  = GAP_LD;
            end
            ST_RELEASE: begin
                tmr_load = tmr_zero;
                tmr_val  = (idx == 2'd3) ? TMO_LD : HOLD_LD;
            end
            default: ;
        endcase
    end

    // NOTE: the code store is plain datapath and has no reset; it is only
    // read after a start has overwritten it.
    always_ff @(posedge i_clk) begin
        if (state == ST_IDLE && start_ok) begin
            for (int i = 0; i < CODE_LEN; i++) begin
                code_q[i] <= i_code[i*SW_W +: SW_W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            idx      <= 2'd0;
            o_switch <= IDLE_PAT;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_pass   <= 1'b0;
            o_fail   <= 1'b0;
        end else if (state != ST_IDLE && i_abort) begin
            state    <= ST_IDLE;
            o_switch <= IDLE_PAT;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_pass   <= 1'b0;
            o_fail   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        o_pass <= 1'b0;
                        o_busy <= 1'b1;
                        idx    <= 2'd0;
                        if (has_idle_word(i_code)) begin
                            state  <= ST_DONE;
                            o_fail <= 1'b1;
                        end else begin
                            state    <= ST_PRESS;
                            o_fail   <= 1'b0;
                            o_switch <= i_code[SW_W-1:0];
                        end
                    end
                end
                ST_PRESS: begin
                    if (tmr_zero) begin
                        state    <= ST_RELEASE;
                        o_switch <= IDLE_PAT;
                    end
                end
                ST_RELEASE: begin
                    if (tmr_zero) begin
                        if (idx != 2'd3) begin
                            idx      <= idx + 2'd1;
                            state    <= ST_PRESS;
                            o_switch <= code_q[idx + 2'd1];
                        end else begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (i_led == LED_OPEN) begin
                        state  <= ST_DONE;
                        o_done <= 1'b1;
                        o_pass <= 1'b1;
                    end else if (tmr_zero) begin
                        state  <= ST_DONE;
                        o_done <= 1'b1;
                        o_fail <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // An illegal code arrives here without the pulse raised;
                    // it gets one extra cycle to emit it.
                    if (!o_done) begin
                        o_done <= 1'b1;
                    end else begin
                        o_done <= 1'b0;
                        o_busy <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_combo_sender.sv
// Directed bench for combo_sender driving a small behavioural combination lock.
module tb_combo_sender;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [19:0] i_code = '0;
    logic [7:0]  i_led = 8'h00;
    logic [4:0]  o_switch;
    logic        o_busy;
    logic        o_done;
    logic        o_pass;
    logic        o_fail;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;

    localparam logic [19:0] CODE_OK    = {5'h07, 5'h0B, 5'h0D, 5'h0E};
    localparam logic [19:0] CODE_WRONG = {5'h07, 5'h0C, 5'h0D, 5'h0E};
    localparam logic [19:0] CODE_ILL   = {5'h07, 5'h0F, 5'h0D, 5'h0E};

    logic [4:0] lock_code [4] = '{5'h0E, 5'h0D, 5'h0B, 5'h07};
    logic [4:0] prev_sw = 5'h0F;
    logic [2:0] prog = 3'd0;

    always #5 i_clk = ~i_clk;

    combo_sender dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_abort  (i_abort),
        .i_code   (i_code),
        .i_led    (i_led),
        .o_switch (o_switch),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_pass   (o_pass),
        .o_fail   (o_fail)
    );

    // Lock: counts correct presses in order, lights all LEDs after the fourth.
    always @(negedge i_clk) begin
        if (i_rst) begin
            prog    = 3'd0;
            prev_sw = 5'h0F;
        end else begin
            if (prev_sw == 5'h0F && o_switch != 5'h0F) begin
                if (prog < 3'd4 && o_switch == lock_code[prog[1:0]]) prog = prog + 3'd1;
                else prog = (o_switch == lock_code[0]) ? 3'd1 : 3'd0;
            end
            prev_sw = o_switch;
        end
        i_led = (prog == 3'd4) ? 8'hFF : {5'd0, prog};
        if (o_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic start_seq(input logic [19:0] code);
        i_code  = code;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        cyc = 1;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic wait_done(input int max_cyc, output int at);
        int n = 0;
        while (!o_done && n < max_cyc) begin
            tick();
            n++;
        end
        at = o_done ? cyc : -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int at;
        int dc0;
        logic [4:0] exp_sw;

        // Reset state
        repeat (3) tick();
        check("rst_switch", o_switch, 5'h0F);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_pass", o_pass, 0);
        check("rst_fail", o_fail, 0);
        i_rst = 1'b0;
        tick();

        // Unlock with the correct code
        start_seq(CODE_OK);
        check("ok_busy_c1", o_busy, 1);
        for (int c = 1; c <= 32; c++) begin
            exp_sw = (((c - 1) % 8) < 4) ? lock_code[(c - 1) / 8] : 5'h0F;
            check($sformatf("ok_sw_c%0d", c), o_switch, exp_sw);
            tick();
        end
        wait_done(30, at);
        check("ok_done_cycle", at, 34);
        check("ok_pass", o_pass, 1);
        check("ok_fail", o_fail, 0);
        tick();
        check("ok_done_low", o_done, 0);
        check("ok_busy_low", o_busy, 0);
        check("ok_pass_sticky", o_pass, 1);

        // Wrong code, with a stray start during CHECK
        tick();
        dc0 = done_cnt;
        start_seq(CODE_WRONG);
        check("wr_pass_cleared", o_pass, 0);
        check("wr_sw_c1", o_switch, 5'h0E);
        run_to(17);
        check("wr_sw_c17", o_switch, 5'h0C);
        run_to(40);
        i_code  = CODE_OK;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_done(30, at);
        check("wr_done_cycle", at, 49);
        check("wr_fail", o_fail, 1);
        check("wr_pass", o_pass, 0);
        repeat (12) tick();
        check("wr_single_done", done_cnt - dc0, 1);
        check("wr_busy_after", o_busy, 0);
        check("wr_fail_sticky", o_fail, 1);

        // Illegal code: word 2 is the idle pattern
        start_seq(CODE_ILL);
        check("ill_sw_c1", o_switch, 5'h0F);
        check("ill_busy_c1", o_busy, 1);
        check("ill_done_c1", o_done, 0);
        tick();
        check("ill_done_c2", o_done, 1);
        check("ill_fail_c2", o_fail, 1);
        check("ill_sw_c2", o_switch, 5'h0F);
        tick();
        check("ill_done_c3", o_done, 0);
        check("ill_busy_c3", o_busy, 0);
        check("ill_sw_c3", o_switch, 5'h0F);

        // Abort in the second press
        tick();
        start_seq(CODE_OK);
        run_to(10);
        check("ab_sw_c10", o_switch, 5'h0D);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        dc0 = done_cnt;
        check("ab_sw", o_switch, 5'h0F);
        check("ab_busy", o_busy, 0);
        check("ab_done", o_done, 0);
        check("ab_pass", o_pass, 0);
        check("ab_fail", o_fail, 0);
        repeat (40) tick();
        check("ab_no_done", done_cnt - dc0, 0);
        check("ab_sw_late", o_switch, 5'h0F);

        // Abort and start together in IDLE: start dropped
        i_abort = 1'b1;
        i_start = 1'b1;
        tick();
        i_abort = 1'b0;
        i_start = 1'b0;
        check("abst_busy", o_busy, 0);
        tick();
        check("abst_sw", o_switch, 5'h0F);

        // Reset during the release after word 1
        start_seq(CODE_OK);
        run_to(14);
        check("rs_sw_c14", o_switch, 5'h0F);
        check("rs_busy_c14", o_busy, 1);
        i_rst = 1'b1;
        tick();
        check("rs_sw", o_switch, 5'h0F);
        check("rs_busy", o_busy, 0);
        check("rs_done", o_done, 0);
        check("rs_pass", o_pass, 0);
        check("rs_fail", o_fail, 0);
        i_rst = 1'b0;
        tick();
        start_seq(CODE_OK);
        check("rp_sw_c1", o_switch, 5'h0E);
        run_to(5);
        check("rp_sw_c5", o_switch, 5'h0F);
        run_to(9);
        check("rp_sw_c9", o_switch, 5'h0D);
        wait_done(40, at);
        check("rp_done_cycle", at, 34);
        check("rp_pass", o_pass, 1);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/combo_sender.md
Name: combo_sender

Overview:
Initiator side of the switch/LED combination-lock interface. It drives a 5-bit switch bus through a four-word code sequence, inserting a release gap after each word. It then watches the lock's 8-bit LED bus to decide pass or fail. It serves as the auto-unlock driver and as the stimulus engine for lock regression benches.

Parameters:
HOLD_CYCLES, 4, cycles each code word is driven on o_switch; legal values are 2 or more.
GAP_CYCLES, 4, cycles the idle pattern is driven after each word; legal values are 1 or more.
TIMEOUT_CYCLES, 16, cycles to wait for the unlocked LED pattern after the final gap.

Ports:
i_clk  in  1  system clock; all logic on its rising edge
i_rst  in  1  synchronous, active-high reset
i_start  in  1  single-cycle request to send the sequence
i_abort  in  1  cancel the sequence in progress
i_code  in  20  code words; bits [4:0] are word 0, up to bits [19:15] for word 3
i_led  in  8  LED bus returned by the lock
o_switch  out  5  switch bus driven to the lock
o_busy  out  1  high from the cycle after an accepted start until the done pulse
o_done  out  1  one-cycle completion pulse
o_pass  out  1  sticky: lock reported unlocked
o_fail  out  1  sticky: timeout or illegal code

Behaviour:
- Constants:
  - Idle pattern IDLE_PAT is 5'h0F.
  - Unlocked pattern LED_OPEN is 8'hFF.
- Reset (i_rst=1 at an edge):
  - State goes to IDLE; index and timer go to 0.
  - o_switch=5'h0F; o_busy=0, o_done=0, o_pass=0, o_fail=0.
  - Reset takes priority over every other input, including mid-sequence. o_switch shows 5'h0F on the very next cycle.
- States: IDLE, PRESS, RELEASE, CHECK, DONE. Encoding is 3 bits.
- IDLE:
  - o_switch=5'h0F.
  - When i_start=1, i_code is latched into an internal 4x5 array, and o_pass and o_fail are cleared.
  - If any latched word equals 5'h0F, the block goes to DONE with o_fail=1 and never drives a press.
  - Otherwise index=0, timer=HOLD_CYCLES-1, and the block goes to PRESS.
  - i_start outside IDLE is ignored.
- PRESS:
  - o_switch=code[index] for exactly HOLD_CYCLES cycles.
  - When the timer reaches 0, timer=GAP_CYCLES-1 and the block goes to RELEASE.
- RELEASE:
  - o_switch=5'h0F for exactly GAP_CYCLES cycles.
  - At the end of the gap: if index<3, index increments, timer reloads HOLD_CYCLES-1, and the block goes to PRESS.
  - If index==3, timer=TIMEOUT_CYCLES-1 and the block goes to CHECK.
  - The index never wraps.
- CHECK:
  - o_switch holds 5'h0F, which keeps an unlocked lock lit.
  - If i_led==8'hFF in any cycle, o_pass is set and the block goes to DONE.
  - If the timer expires first, o_fail is set and the block goes to DONE.
  - If i_led==FF on the same cycle the timer expires, pass wins.
- DONE:
  - o_done=1 for one cycle, then the block returns to IDLE.
  - o_pass and o_fail hold until the next accepted start or reset.
- o_busy is high in PRESS, RELEASE, CHECK and DONE, and low in IDLE.
- Abort:
  - i_abort=1 in any non-IDLE state sends the block to IDLE on the next cycle, with o_switch=5'h0F, no done pulse, and o_pass/o_fail cleared.
  - If i_abort and i_start are both high in IDLE, abort wins and the start is dropped.
- Timing: nominal sequence length from start to CHECK is 4*(HOLD_CYCLES+GAP_CYCLES) cycles. The first code word appears one cycle after the start edge.
- Counters:
  - Timer width is $clog2 of the largest of the three parameters, plus 1 bit.
  - Index is 2 bits.
  - All outputs are registered.

Decomposition:
- Package combo_pkg holds:
  - the state enum;
  - IDLE_PAT (5'h0F);
  - LED_OPEN (8'hFF);
  - CODE_LEN (4);
  - SW_W (5) and LED_W (8).
- One sub-module, combo_phase_timer, is natural: a loadable down-counter with load value, load strobe and zero flag. It is shared by the PRESS, RELEASE and CHECK phases.

Test Plan:
- Unlock with a paired lock model:
  - Stimulus: i_code words 0E,0D,0B,07; default parameters.
  - Required: o_switch reads 0E for cycles 1-4, 0F for 5-8, 0D for 9-12, and so on. i_led reaches FF within the timeout, then o_done pulses with o_pass=1 and o_fail=0.
- Wrong code:
  - Stimulus: i_code words 0E,0D,0C,07 against the same lock.
  - Required: the LEDs never reach FF; o_done pulses exactly TIMEOUT_CYCLES cycles after CHECK entry, with o_fail=1.
- Illegal code:
  - Stimulus: word 2 = 0F.
  - Required: o_switch stays 0F throughout; o_done pulses with o_fail=1 two cycles after start.
- Abort mid-sequence:
  - Stimulus: i_abort asserted in the second PRESS.
  - Required: next cycle o_switch=0F and o_busy=0; no o_done pulse; o_pass=0 and o_fail=0.
- Reset mid-sequence:
  - Stimulus: i_rst asserted in RELEASE of word 1.
  - Required: all outputs at reset values the next cycle. A following start replays from word 0.
- Start while busy:
  - Stimulus: a second i_start pulse during CHECK.
  - Required: it is ignored; the sequence finishes once, with a single o_done pulse.
